dmem_arbiter: RTL

Two-requester arbiter and sequencer for the shared DDR2-backed data cache port. The program loader streams initial data-memory words, and the pipeline core issues loads and stores; both contend for the single `memory_sig` / `read_or_write` / `finish` handshake of the cache. The block replaces the static `program_fin` address/data mux in front of the cache. It serialises one transaction at a time, alternates fairly between requesters, and flags a cache that never answers.

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the shared data-cache port: serialises loader
// writes and core loads/stores, alternates on contention and aborts a silent cache.
module dmem_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_done,
    input  logic              cr_req,
    input  logic              cr_we,
    input  logic [ADDR_W-1:0] cr_addr,
    input  logic [31:0]       cr_wdata,
    output logic [31:0]       cr_rdata,
    output logic              cr_done,
    output logic              cr_stall,
    output logic              mem_sig,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_finish,
    output logic              timeout_err,
    output logic [1:0]        state_dbg
);

    // Handshake: a requester raises req and holds it (with stable addr/data) until its
    // done pulses for one cycle; the cache sees mem_sig held high until mem_finish.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic             owner;   // 1 = core, 0 = loader
    logic             last;    // requester served most recently
    logic [CNT_W-1:0] cnt;
    logic             grant_core;
    logic             timeout_hit;

    // On a tie the requester that was not served last wins.
    assign grant_core  = cr_req & (~ld_req | ~last);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_VAL);
    assign cr_stall    = cr_req & ~cr_done;
    assign state_dbg   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last        <= 1'b0;
            cnt         <= '0;
            mem_sig     <= 1'b0;
            mem_rw      <= 1'b1;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ld_done     <= 1'b0;
            cr_done     <= 1'b0;
            cr_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            cr_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ld_req || cr_req) begin
                        owner     <= grant_core;
                        mem_addr  <= grant_core ? cr_addr : ld_addr;
                        mem_wdata <= grant_core ? cr_wdata : ld_wdata;
                        mem_rw    <= grant_core ? ~cr_we : 1'b0;
                        mem_sig   <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    // A finish in the timeout cycle still counts as a normal completion.
                    if (mem_finish) begin
                        if (owner) cr_done <= 1'b1;
                        else       ld_done <= 1'b1;
                        if (owner && mem_rw) cr_rdata <= mem_rdata;
                        last    <= owner;
                        mem_sig <= 1'b0;
                        state   <= RELEASE;
                    end else if (timeout_hit) begin
                        if (owner) cr_done <= 1'b1;
                        else       ld_done <= 1'b1;
                        if (owner && mem_rw) cr_rdata <= '0;
                        timeout_err <= 1'b1;
                        mem_sig     <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
